// File: rtl/arith_unit_arbiter_pkg.sv
// Shared types and constants for the arith_unit_arbiter slice.
// Holds the FSM state encoding, the op-select encoding and the
// operand/result widths used by the arbiter, its datapath and the bus interface.
package arith_arb_pkg;

    localparam int OPND_W = 3;
    localparam int RES_W  = 6;

    // Packed {op, b, a} word carried from the selected requester into the operand latches.
    localparam int WORD_W = 2 * OPND_W + 1;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_MUL = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/arith_unit_arbiter_if.sv
// Bus bundle between the requesters / response consumer and the arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface arith_unit_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 2
);
    import arith_arb_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [OPND_W*NUM_REQ-1:0] req_a;
    logic [OPND_W*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]        req_op;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [RES_W-1:0]          rsp_data;
    logic [ID_W-1:0]           rsp_id;
    logic [7:0]                ops_done;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, ops_done
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, ops_done
    );

endinterface

// File: rtl/arith_unit_arbiter_3bit.sv
// arith_unit_3bit: shared combinational 3-bit datapath.
// op = 1 adds (carry lands in bit 3), op = 0 multiplies (full 6-bit product).
module arith_unit_3bit
    import arith_arb_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    input  logic              op,
    output logic [RES_W-1:0]  res
);

    logic [OPND_W:0]  sum;
    logic [RES_W-1:0] prod;

    // Both results are computed every cycle; op only steers the output mux.
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        prod = {{(RES_W-OPND_W){1'b0}}, a} * {{(RES_W-OPND_W){1'b0}}, b};
        if (op == OP_ADD) begin
            res = {{(RES_W-OPND_W-1){1'b0}}, sum};
        end else begin
            res = prod;
        end
    end

endmodule

// File: rtl/arith_unit_arbiter.sv
// arith_unit_arbiter: shares one arith_unit_3bit between NUM_REQ requesters.
// One operation at a time runs IDLE (accept) -> EXEC (compute) -> RESP (hold
// until rsp_ready). Results, response id and the completion counter are registered.
// Optional feature macro: ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// when undefined the lowest requesting index wins and no pointer is built.
module arith_unit_arbiter
    import arith_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    arith_unit_arbiter_if.slave  bus
);

    state_t              state_q,     state_d;
    logic [OPND_W-1:0]   a_q,         a_d;
    logic [OPND_W-1:0]   b_q,         b_d;
    logic                op_q,        op_d;
    logic [ID_W-1:0]     id_q,        id_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [RES_W-1:0]    rsp_data_q,  rsp_data_d;
    logic [ID_W-1:0]     rsp_id_q,    rsp_id_d;
    logic [7:0]          ops_done_q,  ops_done_d;

    logic [NUM_REQ-1:0]        grant_oh;
    logic                      grant_any;
    logic [ID_W-1:0]           grant_idx;
    logic [NUM_REQ*WORD_W-1:0] masked_words;
    logic [WORD_W-1:0]         sel_word;
    logic [RES_W-1:0]          alu_res;
    logic                      accept;

    assign grant_any = |bus.req_valid;

`ifdef ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0] rr_mask;
    logic [NUM_REQ-1:0] rr_masked;

    // Requesters strictly above the last grant are searched first; if none is
    // valid the search wraps to the lowest index, giving last_grant+1 mod NUM_REQ.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gen_rr_mask
        assign rr_mask[gi] = (ID_W'(gi) > last_grant_q);
    end

    assign rr_masked = bus.req_valid & rr_mask;

    // Pick the lowest set bit of the masked set, else of the full request set.
    always_comb begin
        if (|rr_masked) begin
            grant_oh = rr_masked & (~rr_masked + NUM_REQ'(1));
        end else begin
            grant_oh = bus.req_valid & (~bus.req_valid + NUM_REQ'(1));
        end
    end

    // Pointer moves to the granted index on every accept.
    always_comb begin
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = grant_idx;
        end
    end

    // Pointer starts at NUM_REQ-1 so requester 0 is searched first after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= ID_W'(NUM_REQ - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    // Fixed priority: isolate the lowest set bit of req_valid.
    always_comb begin
        grant_oh = bus.req_valid & (~bus.req_valid + NUM_REQ'(1));
    end
`endif

    // One-hot to binary: index bit bi is the OR of grant bits whose position has bit bi set.
    for (genvar bi = 0; bi < ID_W; bi++) begin : gen_enc
        logic [NUM_REQ-1:0] col;
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gen_enc_col
            assign col[gi] = (((gi >> bi) % 2) == 1) ? grant_oh[gi] : 1'b0;
        end
        assign grant_idx[bi] = |col;
    end

    // One-hot AND-OR mux of the granted requester's {op, b, a}.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gen_mask_word
        assign masked_words[gi*WORD_W +: WORD_W] = grant_oh[gi]
            ? {bus.req_op[gi], bus.req_b[gi*OPND_W +: OPND_W], bus.req_a[gi*OPND_W +: OPND_W]}
            : '0;
    end

    for (genvar wi = 0; wi < WORD_W; wi++) begin : gen_sel_bit
        logic [NUM_REQ-1:0] col;
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gen_sel_col
            assign col[gi] = masked_words[gi*WORD_W + wi];
        end
        assign sel_word[wi] = |col;
    end

    // Ready is offered only in IDLE and never while reset is asserted.
    assign bus.req_ready = (state_q == IDLE && !rst) ? grant_oh : '0;

    arith_unit_3bit u_alu (
        .a   (a_q),
        .b   (b_q),
        .op  (op_q),
        .res (alu_res)
    );

    // FSM next-state, operand latching, response capture and completion counting.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        ops_done_d  = ops_done_q;
        accept      = 1'b0;
        case (state_q)
            IDLE: begin
                // Any valid request is granted, so a valid request means a handshake.
                if (grant_any) begin
                    accept  = 1'b1;
                    a_d     = sel_word[OPND_W-1:0];
                    b_d     = sel_word[2*OPND_W-1:OPND_W];
                    op_d    = sel_word[WORD_W-1];
                    id_d    = grant_idx;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = alu_res;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ops_done_d  = ops_done_q + 8'd1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 1'b0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            ops_done_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            ops_done_q  <= ops_done_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.ops_done  = ops_done_q;

endmodule

// File: doc/arith_unit_arbiter.md
# arith_unit_arbiter

Shares one 3-bit add/multiply datapath between NUM_REQ requesters. Each requester issues a valid/ready operation (add or multiply of two 3-bit operands). The arbiter grants one request at a time, sequences it through the datapath, and returns a registered 6-bit result with the requester's index on a single response channel. It sits between the input-pin decode logic and the output-pin mux, replacing direct combinational wiring of the datapath.

## Interface
- NUM_REQ, default 2, number of requesters (2..4).
- ID_W, default 2, width of the requester index; must satisfy 2**ID_W >= NUM_REQ.
- clk  in  1  clock; all state on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept strobe.
- req_a  in  3*NUM_REQ  operand A, slice i belongs to requester i.
- req_b  in  3*NUM_REQ  operand B, slice i.
- req_op  in  NUM_REQ  per-requester op select: 1 = add, 0 = multiply.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumer ready.
- rsp_data  out  6  result.
- rsp_id  out  ID_W  index of the requester that owns rsp_data.
- ops_done  out  8  count of completed responses.

## Operation
- FSM states are IDLE, EXEC and RESP.
- **IDLE:**
  - grant = arbitration over req_valid.
  - req_ready[g] = 1 for the granted index only, combinationally. Every other bit of req_ready is 0.
  - On req_valid[g] & req_ready[g]: latch a, b, op and id = g, then go to EXEC.
  - With no valid requests, stay in IDLE.
- **EXEC:**
  - Datapath output is registered into rsp_data; rsp_id <= id.
  - Next state is RESP.
  - req_ready is all 0.
- **RESP:**
  - rsp_valid = 1; rsp_data and rsp_id are held stable.
  - On rsp_ready, go to IDLE and increment ops_done. ops_done wraps 255 -> 0.
  - req_ready is all 0.
- **Arithmetic:**
  - Add result = {2'b00, cout, sum[2:0]}.
  - Multiply result = full 6-bit a*b, maximum 49.
  - Operands are unsigned.
- **Requester rules:**
  - A requester holds req_valid and its operands stable until it sees req_ready.
  - Grant never depends on rsp_ready.
- **Boundary cases:**
  - Requests arriving while the arbiter is in EXEC or RESP wait; they are not dropped.
  - rsp_ready held high makes the RESP dwell exactly 1 cycle.
  - rst asserted mid-operation discards the in-flight operation. Requesters must reissue it.
  - req_valid deasserted by a non-granted requester has no effect.

## Timing
- Reset values:
  - State IDLE.
  - req_ready = 0 while rst is high.
  - rsp_valid = 0, rsp_data = 0, rsp_id = 0, ops_done = 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has priority first.
- Latency: accept in cycle T, EXEC in T+1, rsp_valid high from T+2.
- Throughput: the next accept can happen no earlier than the cycle after the response handshake, i.e. one op per 3 cycles at best.
- rsp_valid, rsp_data, rsp_id and ops_done are registered outputs. req_ready is combinational from state and req_valid.

## Configuration
- Macro: ARB_ROUND_ROBIN_EN.
- **Defined:** round-robin arbitration.
  - Search starts at last_grant+1 modulo NUM_REQ.
  - last_grant updates on each accept.
  - Any requester holding valid is served within NUM_REQ grants.
- **Undefined:** fixed priority.
  - The lowest index with req_valid wins.
  - The pointer register is not built.

## Structure
- Shared package arith_arb_pkg holds:
  - state enum {IDLE, EXEC, RESP};
  - OP_ADD = 1'b1 and OP_MUL = 1'b0;
  - RES_W = 6 and OPND_W = 3.
- One sub-module, arith_unit_3bit: purely combinational. Inputs a[2:0], b[2:0], op; output res[5:0] per the arithmetic rules above.
- The arbiter top holds the FSM, operand latches, arbitration logic, response registers and the counter.

## Test plan
- **Reset:** assert rst mid-RESP -> all outputs return to their reset values immediately; state IDLE after release.
- **Single add:** req0 add a=7, b=7 -> accept at T; rsp_valid at T+2, rsp_data=14, rsp_id=0; ops_done=1 after rsp_ready.
- **Single multiply:** req1 mul a=7, b=7 -> rsp_data=49, rsp_id=1. Also mul a=5, b=0 -> 0.
- **Contention, round-robin:** with ARB_ROUND_ROBIN_EN defined and both requesters continuously valid -> grant order 0,1,0,1. Without the macro -> order 0,0,0 and req1 starves.
- **Backpressure:** hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data and rsp_id stable; req_ready stays 0; the pending req1 is accepted the cycle after the handshake.
- **Counter wrap:** 256 back-to-back operations -> ops_done returns to 0 and the 257th response counts to 1.
